// File: rtl/ooo_scoreboard.sv
`default_nettype none
// ============================================================================
// ooo_scoreboard : in-order issue / out-of-order writeback / in-order commit
//   tracker with rs1/rs2 operand lookup; forwarding enabled by SB_FORWARD_EN.
// Revision: 1.0
// ============================================================================

package OoO_pkg;
  localparam int ScoreboardDepth = 4;
  localparam int ScoreboardIndex = 2;
  localparam int WriteBackPorts  = 2;

  typedef enum logic [2:0] {
    FU_NONE   = 3'd0,
    FU_ALU    = 3'd1,
    FU_LSU    = 3'd2,
    FU_MULT   = 3'd3,
    FU_BRANCH = 3'd4
  } fu_t;

  typedef struct packed {
    fu_t                        fu;
    logic [7:0]                 op;
    logic [4:0]                 rs1;
    logic [4:0]                 rs2;
    logic [4:0]                 rd;
    logic [31:0]                result;
    logic [ScoreboardIndex-1:0] trans_id;
  } decoder_t;

  typedef struct packed {
    logic                       valid;
    logic [ScoreboardIndex-1:0] idx;
    logic [31:0]                data;
    logic                       ex_valid;
  } writeback_t;
endpackage

module ooo_scoreboard #(
  parameter int NR_ENTRIES = OoO_pkg::ScoreboardDepth,
  parameter int IDX_W      = OoO_pkg::ScoreboardIndex,
  parameter int NR_WB      = OoO_pkg::WriteBackPorts
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush_i,
  input  logic                issue_valid_i,
  input  OoO_pkg::decoder_t   issue_instr_i,
  output logic                issue_ready_o,
  output logic [IDX_W-1:0]    issue_id_o,
  input  OoO_pkg::writeback_t wb_i [NR_WB],
  input  logic [4:0]          rs1_i,
  input  logic [4:0]          rs2_i,
  output logic                rs1_busy_o,
  output logic                rs2_busy_o,
  output logic                rs1_fwd_o,
  output logic                rs2_fwd_o,
  output logic [31:0]         rs1_data_o,
  output logic [31:0]         rs2_data_o,
  output logic                commit_valid_o,
  output OoO_pkg::decoder_t   commit_instr_o,
  output logic                commit_ex_o,
  input  logic                commit_ack_i,
  output logic                full_o
);

  logic [NR_ENTRIES-1:0] valid_q, valid_d;
  logic [NR_ENTRIES-1:0] done_q, done_d;
  logic [NR_ENTRIES-1:0] ex_q, ex_d;
  OoO_pkg::decoder_t     instr_q [NR_ENTRIES];
  OoO_pkg::decoder_t     instr_d [NR_ENTRIES];
  logic [IDX_W-1:0]      issue_ptr_q, issue_ptr_d;
  logic [IDX_W-1:0]      commit_ptr_q, commit_ptr_d;
  logic [IDX_W:0]        count_q, count_d;

  logic                  w_issue;
  logic                  w_commit;
  logic [4:0]            w_rs   [2];
  logic                  w_busy [2];
  logic                  w_fwd  [2];
  logic [31:0]           w_data [2];

  assign full_o         = (count_q == (IDX_W+1)'(NR_ENTRIES));
  assign issue_ready_o  = !full_o;
  assign issue_id_o     = issue_ptr_q;
  assign w_issue        = issue_valid_i & issue_ready_o;
  assign commit_valid_o = valid_q[commit_ptr_q] & done_q[commit_ptr_q];
  assign commit_ex_o    = ex_q[commit_ptr_q];
  assign commit_instr_o = instr_q[commit_ptr_q];
  assign w_commit       = commit_valid_o & commit_ack_i;

  always_comb begin
    valid_d      = valid_q;
    done_d       = done_q;
    ex_d         = ex_q;
    instr_d      = instr_q;
    issue_ptr_d  = issue_ptr_q;
    commit_ptr_d = commit_ptr_q;
    count_d      = count_q;

    // Highest port first so the lowest-numbered port overwrites on a collision.
    for (int k = NR_WB - 1; k >= 0; k--) begin
      if (wb_i[k].valid && valid_q[wb_i[k].idx] && !done_q[wb_i[k].idx]) begin
        done_d[wb_i[k].idx]         = 1'b1;
        ex_d[wb_i[k].idx]           = wb_i[k].ex_valid;
        instr_d[wb_i[k].idx].result = wb_i[k].data;
      end
    end

    if (w_commit) begin
      valid_d[commit_ptr_q] = 1'b0;
      commit_ptr_d          = commit_ptr_q + IDX_W'(1);
    end

    // Issue slot is never valid here, so no writeback can target it this cycle.
    if (w_issue) begin
      valid_d[issue_ptr_q]          = 1'b1;
      done_d[issue_ptr_q]           = (issue_instr_i.fu == OoO_pkg::FU_NONE);
      ex_d[issue_ptr_q]             = 1'b0;
      instr_d[issue_ptr_q]          = issue_instr_i;
      instr_d[issue_ptr_q].trans_id = issue_ptr_q;
      issue_ptr_d                   = issue_ptr_q + IDX_W'(1);
    end

    case ({w_issue, w_commit})
      2'b10:   count_d = count_q + (IDX_W+1)'(1);
      2'b01:   count_d = count_q - (IDX_W+1)'(1);
      default: count_d = count_q;
    endcase

    if (flush_i) begin
      valid_d      = '0;
      done_d       = '0;
      ex_d         = '0;
      issue_ptr_d  = '0;
      commit_ptr_d = '0;
      count_d      = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q      <= '0;
      done_q       <= '0;
      ex_q         <= '0;
      issue_ptr_q  <= '0;
      commit_ptr_q <= '0;
      count_q      <= '0;
      for (int i = 0; i < NR_ENTRIES; i++) begin
        instr_q[i] <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      done_q       <= done_d;
      ex_q         <= ex_d;
      issue_ptr_q  <= issue_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      count_q      <= count_d;
      for (int i = 0; i < NR_ENTRIES; i++) begin
        instr_q[i] <= instr_d[i];
      end
    end
  end

  assign w_rs[0] = rs1_i;
  assign w_rs[1] = rs2_i;

  // Walk oldest to youngest so the last match is the youngest producer.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_busy[p] = 1'b0;
      w_fwd[p]  = 1'b0;
      w_data[p] = '0;
      for (int i = 0; i < NR_ENTRIES; i++) begin
        if (valid_q[commit_ptr_q + IDX_W'(i)] &&
            (instr_q[commit_ptr_q + IDX_W'(i)].rd == w_rs[p]) &&
            (w_rs[p] != 5'd0)) begin
          w_busy[p] = 1'b1;
`ifdef SB_FORWARD_EN
          w_fwd[p]  = done_q[commit_ptr_q + IDX_W'(i)];
          w_data[p] = instr_q[commit_ptr_q + IDX_W'(i)].result;
`else
          w_fwd[p]  = 1'b0;
          w_data[p] = '0;
`endif
        end
      end
    end
  end

  assign rs1_busy_o = w_busy[0];
  assign rs2_busy_o = w_busy[1];
  assign rs1_fwd_o  = w_fwd[0];
  assign rs2_fwd_o  = w_fwd[1];
  assign rs1_data_o = w_data[0];
  assign rs2_data_o = w_data[1];

endmodule

`default_nettype wire

// File: tb/tb_ooo_scoreboard.sv
`default_nettype none
// tb_ooo_scoreboard : queue-based scoreboard bench for ooo_scoreboard.
module tb_ooo_scoreboard;
  import OoO_pkg::*;

  localparam int NR  = 4;
  localparam int NWB = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush_i;
  logic        issue_valid_i;
  decoder_t    issue_instr_i;
  logic        issue_ready_o;
  logic [1:0]  issue_id_o;
  writeback_t  wb_i [NWB];
  logic [4:0]  rs1_i, rs2_i;
  logic        rs1_busy_o, rs2_busy_o, rs1_fwd_o, rs2_fwd_o;
  logic [31:0] rs1_data_o, rs2_data_o;
  logic        commit_valid_o;
  decoder_t    commit_instr_o;
  logic        commit_ex_o;
  logic        commit_ack_i;
  logic        full_o;

  ooo_scoreboard dut (
    .clock          (clock),
    .reset          (reset),
    .flush_i        (flush_i),
    .issue_valid_i  (issue_valid_i),
    .issue_instr_i  (issue_instr_i),
    .issue_ready_o  (issue_ready_o),
    .issue_id_o     (issue_id_o),
    .wb_i           (wb_i),
    .rs1_i          (rs1_i),
    .rs2_i          (rs2_i),
    .rs1_busy_o     (rs1_busy_o),
    .rs2_busy_o     (rs2_busy_o),
    .rs1_fwd_o      (rs1_fwd_o),
    .rs2_fwd_o      (rs2_fwd_o),
    .rs1_data_o     (rs1_data_o),
    .rs2_data_o     (rs2_data_o),
    .commit_valid_o (commit_valid_o),
    .commit_instr_o (commit_instr_o),
    .commit_ex_o    (commit_ex_o),
    .commit_ack_i   (commit_ack_i),
    .full_o         (full_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  id;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ex;
    bit          done;
  } rec_t;

  rec_t       sb [$];
  logic [1:0] next_id;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int youngest(input logic [4:0] rs);
    int r = -1;
    if (rs != 5'd0) begin
      foreach (sb[i]) if (sb[i].rd == rs) r = i;
    end
    return r;
  endfunction

  task automatic chk_lookup(input string tag, input logic [4:0] rs, input logic busy,
                            input logic fwd, input logic [31:0] data);
    int y;
    y = youngest(rs);
    chk({tag, "_busy"}, busy, y >= 0);
`ifdef SB_FORWARD_EN
    chk({tag, "_fwd"}, fwd, (y >= 0) ? sb[y].done : 1'b0);
    chk({tag, "_data"}, data, (y >= 0) ? sb[y].data : 32'd0);
`else
    chk({tag, "_fwd"}, fwd, 1'b0);
    chk({tag, "_data"}, data, 32'd0);
`endif
  endtask

  // Compare against the model, then advance it by what the coming edge does.
  task automatic check_cycle();
    logic cv;
    int   sz;
    sz = sb.size();
    cv = (sz > 0) && sb[0].done;
    chk("commit_valid", commit_valid_o, cv);
    chk("full", full_o, sz == NR);
    chk("issue_ready", issue_ready_o, sz < NR);
    chk("issue_id", issue_id_o, next_id);
    chk_lookup("rs1", rs1_i, rs1_busy_o, rs1_fwd_o, rs1_data_o);
    chk_lookup("rs2", rs2_i, rs2_busy_o, rs2_fwd_o, rs2_data_o);
    if (commit_ack_i && cv) begin
      chk("commit_data", commit_instr_o.result, sb[0].data);
      chk("commit_id", commit_instr_o.trans_id, sb[0].id);
      chk("commit_ex", commit_ex_o, sb[0].ex);
    end
    if (flush_i) begin
      sb.delete();
      next_id = 2'd0;
    end else begin
      for (int k = 0; k < NWB; k++) begin
        if (wb_i[k].valid) begin
          foreach (sb[i]) begin
            if (sb[i].id == wb_i[k].idx && !sb[i].done) begin
              sb[i].done = 1'b1;
              sb[i].data = wb_i[k].data;
              sb[i].ex   = wb_i[k].ex_valid;
            end
          end
        end
      end
      if (commit_ack_i && cv) void'(sb.pop_front());
      if (issue_valid_i && sz < NR) begin
        sb.push_back('{id: next_id, rd: issue_instr_i.rd, data: issue_instr_i.result,
                       ex: 1'b0, done: (issue_instr_i.fu == FU_NONE)});
        next_id = next_id + 2'd1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clock);
    check_cycle();
    @(posedge clock);
    #1;
    issue_valid_i = 1'b0;
    commit_ack_i  = 1'b0;
    flush_i       = 1'b0;
    for (int k = 0; k < NWB; k++) wb_i[k].valid = 1'b0;
  endtask

  task automatic iss(input logic [4:0] rd, input fu_t fu, input logic [31:0] res);
    issue_valid_i          = 1'b1;
    issue_instr_i.fu       = fu;
    issue_instr_i.op       = 8'h5A;
    issue_instr_i.rs1      = 5'd0;
    issue_instr_i.rs2      = 5'd0;
    issue_instr_i.rd       = rd;
    issue_instr_i.result   = res;
    issue_instr_i.trans_id = 2'b11;
  endtask

  task automatic wb(input int port, input logic [1:0] id, input logic [31:0] data, input logic ex);
    wb_i[port].valid    = 1'b1;
    wb_i[port].idx      = id;
    wb_i[port].data     = data;
    wb_i[port].ex_valid = ex;
  endtask

  initial begin
    flush_i       = 1'b0;
    issue_valid_i = 1'b0;
    issue_instr_i = '0;
    commit_ack_i  = 1'b0;
    rs1_i         = 5'd1;
    rs2_i         = 5'd4;
    for (int k = 0; k < NWB; k++) wb_i[k] = '0;
    next_id = 2'd0;

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_ready", issue_ready_o, 1'b1);
    chk("rst_id", issue_id_o, 2'd0);
    chk("rst_cv", commit_valid_o, 1'b0);
    chk("rst_full", full_o, 1'b0);
    chk("rst_busy", rs1_busy_o, 1'b0);
    chk("rst_fwd", rs1_fwd_o, 1'b0);
    chk("rst_data", rs1_data_o, 32'd0);
    tick();

    // Fill with four ALU ops, then try a fifth
    for (int i = 0; i < 4; i++) begin
      chk("fill_id", issue_id_o, i[1:0]);
      iss(5'(i + 1), FU_ALU, 32'd0);
      tick();
    end
    chk("full_after4", full_o, 1'b1);
    chk("ready_after4", issue_ready_o, 1'b0);
    iss(5'd9, FU_ALU, 32'd0);
    tick();
    chk("full_held", full_o, 1'b1);

    // Out-of-order writeback, in-order commit
    wb(0, 2'd2, 32'h22, 1'b0); tick();
    chk("cv_id2_only", commit_valid_o, 1'b0);
    wb(1, 2'd0, 32'h10, 1'b0); tick();
    chk("cv_after_wb0", commit_valid_o, 1'b1);
    chk("head_data0", commit_instr_o.result, 32'h10);
    wb(0, 2'd1, 32'h11, 1'b0); commit_ack_i = 1'b1; tick();
    chk("head_data1", commit_instr_o.result, 32'h11);
    commit_ack_i = 1'b1; tick();
    chk("head_data2", commit_instr_o.result, 32'h22);
    commit_ack_i = 1'b1; tick();
    chk("id3_blocks", commit_valid_o, 1'b0);
    commit_ack_i = 1'b1; tick();

    // Dual writeback to one slot, writeback to an empty slot
    iss(5'd6, FU_ALU, 32'd0); tick();
    iss(5'd7, FU_ALU, 32'd0); tick();
    wb(0, 2'd1, 32'hAA, 1'b1); wb(1, 2'd1, 32'hBB, 1'b0); tick();
    wb(0, 2'd2, 32'hEE, 1'b0); tick();
    wb(0, 2'd3, 32'h33, 1'b0); wb(1, 2'd0, 32'h40, 1'b0); tick();
    commit_ack_i = 1'b1; tick();
    commit_ack_i = 1'b1; tick();
    chk("dual_data", commit_instr_o.result, 32'hAA);
    chk("dual_ex", commit_ex_o, 1'b1);
    commit_ack_i = 1'b1; tick();

    // Two producers of x5: lookup tracks the youngest
    rs1_i = 5'd5;
    iss(5'd5, FU_ALU, 32'd0); tick();
    iss(5'd5, FU_ALU, 32'd0); tick();
    chk("slot2_not_done", commit_valid_o, 1'b0);
    wb(0, 2'd2, 32'h5, 1'b0); tick();
    chk("x5_busy", rs1_busy_o, 1'b1);
    chk("x5_fwd_pending", rs1_fwd_o, 1'b0);
    wb(0, 2'd3, 32'h7, 1'b0); tick();
`ifdef SB_FORWARD_EN
    chk("x5_fwd", rs1_fwd_o, 1'b1);
    chk("x5_data", rs1_data_o, 32'h7);
`else
    chk("x5_fwd", rs1_fwd_o, 1'b0);
    chk("x5_data", rs1_data_o, 32'h0);
`endif
    rs1_i = 5'd0; #1;
    chk("x0_busy", rs1_busy_o, 1'b0);
    commit_ack_i = 1'b1; tick();
    commit_ack_i = 1'b1; tick();

    // Full with commit and issue in the same cycle
    rs1_i = 5'd12;
    for (int i = 0; i < 4; i++) begin
      iss(5'(10 + i), FU_ALU, 32'd0); tick();
    end
    wb(0, 2'd0, 32'h100, 1'b0); tick();
    commit_ack_i = 1'b1; iss(5'd14, FU_ALU, 32'd0); tick();
    chk("full_drop_full", full_o, 1'b0);
    chk("full_drop_ready", issue_ready_o, 1'b1);
    chk("wrap_id", issue_id_o, 2'd0);
    iss(5'd14, FU_ALU, 32'd0); tick();
    chk("refull", full_o, 1'b1);

    // Flush with three in flight plus issue and writeback
    wb(0, 2'd1, 32'h101, 1'b0); tick();
    commit_ack_i = 1'b1; tick();
    flush_i = 1'b1; iss(5'd15, FU_ALU, 32'd0); wb(0, 2'd2, 32'h102, 1'b0); tick();
    chk("flush_full", full_o, 1'b0);
    chk("flush_id", issue_id_o, 2'd0);
    chk("flush_cv", commit_valid_o, 1'b0);
    chk("flush_busy", rs1_busy_o, 1'b0);

    // FU_NONE completes without writeback
    iss(5'd3, FU_NONE, 32'hAB); tick();
    chk("none_cv", commit_valid_o, 1'b1);
    chk("none_data", commit_instr_o.result, 32'hAB);
    commit_ack_i = 1'b1; tick();

    // Asynchronous reset mid-operation
    rs1_i = 5'd20;
    iss(5'd20, FU_ALU, 32'd0); tick();
    iss(5'd21, FU_NONE, 32'd0); tick();
    reset = 1'b1;
    #1;
    chk("arst_cv", commit_valid_o, 1'b0);
    chk("arst_id", issue_id_o, 2'd0);
    chk("arst_busy", rs1_busy_o, 1'b0);
    chk("arst_full", full_o, 1'b0);
    sb.delete();
    next_id = 2'd0;
    tick();
    reset = 1'b0;
    iss(5'd20, FU_ALU, 32'd0); tick();
    chk("post_rst_busy", rs1_busy_o, 1'b1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
